// File: rtl/vga_timing_rx_if.sv
// Sync inputs and recovered-timing outputs of the VGA timing receiver.
// master = sync source / consumer side, slave = the receiver itself.
interface vga_timing_rx_if;
  logic        hsync;
  logic        vsync;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        pix_valid;
  logic        locked;
  logic        frame_start;
  logic        err;
  logic [10:0] h_period;
  logic [9:0]  v_period;

  modport master (
    output hsync, vsync,
    input  x, y, pix_valid, locked, frame_start, err, h_period, v_period
  );

  modport slave (
    input  hsync, vsync,
    output x, y, pix_valid, locked, frame_start, err, h_period, v_period
  );
endinterface

// File: rtl/vga_timing_rx.sv
// VGA timing receiver: locks to hsync/vsync cadence, rebuilds pixel x/y,
// measures line/frame periods and flags timing errors.
module vga_timing_rx #(
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic           dclk,
  input  logic           clr,
  vga_timing_rx_if.slave vga
);

  localparam logic [10:0] H_START  = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END    = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_START  = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_END    = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [2:0]  LOCK_N   = 3'(LOCK_FRAMES);
  localparam logic [10:0] HCNT_MAX = '1;
  localparam logic [9:0]  VCNT_MAX = '1;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      state, state_n;
  logic        hs_s1, hs_s2, vs_s1, vs_s2;
  logic        hfall, vfall;
  logic [10:0] hcnt;
  logic [9:0]  vcnt;
  logic [2:0]  good_cnt, good_n;
  logic        first_line, first_n;
  logic        bad_seen, bad_n;
  logic        err_n, fs_n;
  logic        line_bad, frame_len_bad, timeout, pix_n;

  always_ff @(posedge dclk) begin
    if (clr) begin
      hs_s1 <= 1'b0;
      hs_s2 <= 1'b0;
      vs_s1 <= 1'b0;
      vs_s2 <= 1'b0;
    end else begin
      hs_s1 <= vga.hsync;
      hs_s2 <= hs_s1;
      vs_s1 <= vga.vsync;
      vs_s2 <= vs_s1;
    end
  end

  assign hfall = hs_s2 & ~hs_s1;
  assign vfall = vs_s2 & ~vs_s1;

  always_ff @(posedge dclk) begin
    if (clr) begin
      hcnt         <= '0;
      vcnt         <= '0;
      vga.h_period <= '0;
      vga.v_period <= '0;
    end else begin
      if (hfall)
        hcnt <= '0;
      else if (hcnt != HCNT_MAX)
        hcnt <= hcnt + 11'd1;

      if (vfall)
        vcnt <= '0;
      else if (hfall && vcnt != VCNT_MAX)
        vcnt <= vcnt + 10'd1;

      if (hfall)
        vga.h_period <= hcnt + 11'd1;
      if (vfall)
        vga.v_period <= vcnt + 10'd1;
    end
  end

  // Fires only on the cycle hcnt steps into saturation, so a stalled hsync
  // reports once rather than every cycle.
  assign timeout       = ~hfall & (hcnt == HCNT_MAX - 11'd1);
  assign line_bad      = hfall & ~first_line & (hcnt != H_LAST);
  assign frame_len_bad = (vcnt != V_LAST);

  assign pix_n = vga.locked
               & (hcnt >= H_START) & (hcnt <= H_END)
               & (vcnt >= V_START) & (vcnt <= V_END);

  always_ff @(posedge dclk) begin
    if (clr) begin
      vga.x         <= '0;
      vga.y         <= '0;
      vga.pix_valid <= 1'b0;
    end else begin
      vga.pix_valid <= pix_n;
      if (pix_n) begin
        vga.x <= 10'(hcnt - H_START);
        vga.y <= vcnt - V_START;
      end
    end
  end

  always_ff @(posedge dclk) begin
    if (clr) begin
      state           <= SEARCH;
      good_cnt        <= '0;
      first_line      <= 1'b1;
      bad_seen        <= 1'b0;
      vga.err         <= 1'b0;
      vga.frame_start <= 1'b0;
      vga.locked      <= 1'b0;
    end else begin
      state           <= state_n;
      good_cnt        <= good_n;
      first_line      <= first_n;
      bad_seen        <= bad_n;
      vga.err         <= err_n;
      vga.frame_start <= fs_n;
      vga.locked      <= (state == LOCKED);
    end
  end

  always_comb begin
    state_n = state;
    good_n  = good_cnt;
    first_n = first_line;
    bad_n   = bad_seen;
    err_n   = 1'b0;
    fs_n    = 1'b0;
    if (timeout) begin
      err_n   = 1'b1;
      state_n = SEARCH;
    end else begin
      unique case (state)
        SEARCH: begin
          good_n  = '0;
          first_n = 1'b1;
          bad_n   = 1'b0;
          if (vfall)
            state_n = MEASURE;
        end
        MEASURE: begin
          if (hfall)
            first_n = 1'b0;
          // The line closing at a coincident vfall counts toward that frame.
          if (vfall) begin
            bad_n = 1'b0;
            if (bad_seen || line_bad || frame_len_bad) begin
              err_n  = 1'b1;
              good_n = '0;
            end else if (good_cnt + 3'd1 == LOCK_N) begin
              good_n  = '0;
              state_n = LOCKED;
            end else begin
              good_n = good_cnt + 3'd1;
            end
          end else if (line_bad) begin
            bad_n = 1'b1;
          end
        end
        LOCKED: begin
          bad_n = 1'b0;
          fs_n  = vfall;
          if (line_bad || (vfall && frame_len_bad)) begin
            err_n   = 1'b1;
            good_n  = '0;
            state_n = MEASURE;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

endmodule
